// File: rtl/pc_trace_buffer.sv
// pc_trace_buffer: captures a stream of fetched PCs/instructions, delays each
// capture through a short history window, and emits the delayed entry as a
// sequence-numbered record into a first-word-fall-through output FIFO.
// Records stop after MAX_RECORDS (done), and records that find the FIFO full
// are dropped (overflow). Both flags are sticky until reset.
module pc_trace_buffer #(
  parameter int DATA_W      = 32,
  parameter int HIST_DEPTH  = 5,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_RECORDS = 5000,
  parameter int SKIP_ZERO   = 1,
  localparam int SEQ_W      = $clog2(MAX_RECORDS + 1),
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_stall,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] inst,
  input  logic              rec_ready,
  output logic              rec_valid,
  output logic [DATA_W-1:0] rec_pc,
  output logic [DATA_W-1:0] rec_inst,
  output logic [SEQ_W-1:0]  rec_seq,
  output logic [LVL_W-1:0]  level,
  output logic              done,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  // Capture tracking and history window
  logic [DATA_W-1:0] last_pc;
  logic              hist_valid [HIST_DEPTH];
  logic [DATA_W-1:0] hist_pc    [HIST_DEPTH];
  logic [DATA_W-1:0] hist_inst  [HIST_DEPTH];

  // Record storage; contents are only meaningful where level says so
  logic [DATA_W-1:0] mem_pc   [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_inst [FIFO_DEPTH];
  logic [SEQ_W-1:0]  mem_seq  [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Record numbering
  logic [SEQ_W-1:0]  count;

  // Datapath control
  logic              capture;
  logic              cand_valid;
  logic [DATA_W-1:0] cand_pc;
  logic [DATA_W-1:0] cand_inst;
  logic              cand_ok;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic              drop;

  // A repeated PC is the same fetch still in flight, so only a changed PC
  // while the CPU is advancing counts as a new capture.
  assign capture = !cpu_stall && (pc != last_pc);

  // The candidate is whichever entry lands in the last history slot on this
  // capture: the incoming fetch itself for a one-deep window, otherwise the
  // entry currently sitting one slot short of the end.
  generate
    if (HIST_DEPTH == 1) begin : g_direct
      assign cand_valid = 1'b1;
      assign cand_pc    = pc;
      assign cand_inst  = inst;
    end else begin : g_window
      assign cand_valid = hist_valid[HIST_DEPTH-2];
      assign cand_pc    = hist_pc[HIST_DEPTH-2];
      assign cand_inst  = hist_inst[HIST_DEPTH-2];
    end
  endgenerate

  assign cand_ok = capture && cand_valid && !done &&
                   !((SKIP_ZERO != 0) && (cand_pc == '0));

  assign rec_valid = (level != '0);
  assign fifo_full = (level == LVL_W'(FIFO_DEPTH));
  assign pop       = rec_valid && rec_ready;

  // A full FIFO can still take a record when the head leaves on the same edge.
  assign push = cand_ok && (!fifo_full || pop);
  assign drop = cand_ok && fifo_full && !pop;

  // Head of the FIFO falls through to the outputs; idle outputs read as zero.
  assign rec_pc   = rec_valid ? mem_pc[rd_ptr]   : '0;
  assign rec_inst = rec_valid ? mem_inst[rd_ptr] : '0;
  assign rec_seq  = rec_valid ? mem_seq[rd_ptr]  : '0;

  // Remember the most recently captured PC for change detection
  always_ff @(posedge clk) begin
    if (reset) begin
      last_pc <= '0;
    end else if (capture) begin
      last_pc <= pc;
    end
  end

  // Shift the history window on every capture, newest entry in slot 0
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_valid[i] <= 1'b0;
      end
    end else if (capture) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hist_valid[i] <= hist_valid[i-1];
        hist_pc[i]    <= hist_pc[i-1];
        hist_inst[i]  <= hist_inst[i-1];
      end
      hist_valid[0] <= 1'b1;
      hist_pc[0]    <= pc;
      hist_inst[0]  <= inst;
    end
  end

  // Write accepted records into storage at the write pointer
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= cand_pc;
      mem_inst[wr_ptr] <= cand_inst;
      mem_seq[wr_ptr]  <= count;
    end
  end

  // Advance FIFO pointers and occupancy on push/pop
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Number accepted records and raise done once the last allowed one is in
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else if (push) begin
      count <= count + SEQ_W'(1);
      if (count == SEQ_W'(MAX_RECORDS - 1)) begin
        done <= 1'b1;
      end
    end
  end

  // Remember that a record was lost to a full FIFO
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_trace_buffer.sv
// tb_pc_trace_buffer: self-checking bench for pc_trace_buffer. Three instances
// share stimulus (default, MAX_RECORDS=3/HIST_DEPTH=1, HIST_DEPTH=1); one is
// selected at a time and compared against a queue of expected records.
module tb_pc_trace_buffer;

  logic        clk;
  logic        reset;
  logic        cpu_stall;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        rec_ready;

  logic        d0_valid, d1_valid, d2_valid;
  logic [31:0] d0_pc, d1_pc, d2_pc;
  logic [31:0] d0_inst, d1_inst, d2_inst;
  logic [12:0] d0_seq, d2_seq;
  logic [1:0]  d1_seq;
  logic [3:0]  d0_level, d1_level, d2_level;
  logic        d0_done, d1_done, d2_done;
  logic        d0_ovf, d1_ovf, d2_ovf;

  int          sel;
  logic        cur_valid, cur_done, cur_ovf;
  logic [31:0] cur_pc, cur_inst, cur_seq, cur_level;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          seq;
  } rec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct {
    bit          stall;
    logic [31:0] pc;
    bit          ready;
    int          exp_level;
  } vec_t;

  rec_t        exp_q[$];
  ent_t        hq[$];
  logic [31:0] m_last;
  int          m_count;
  bit          m_done;
  bit          m_ovf;
  int          m_hist;
  int          m_max;

  pc_trace_buffer dut0 (
    .clk(clk), .reset(reset), .cpu_stall(cpu_stall), .pc(pc), .inst(inst),
    .rec_ready(rec_ready), .rec_valid(d0_valid), .rec_pc(d0_pc),
    .rec_inst(d0_inst), .rec_seq(d0_seq), .level(d0_level), .done(d0_done),
    .overflow(d0_ovf)
  );

  pc_trace_buffer #(.HIST_DEPTH(1), .MAX_RECORDS(3)) dut1 (
    .clk(clk), .reset(reset), .cpu_stall(cpu_stall), .pc(pc), .inst(inst),
    .rec_ready(rec_ready), .rec_valid(d1_valid), .rec_pc(d1_pc),
    .rec_inst(d1_inst), .rec_seq(d1_seq), .level(d1_level), .done(d1_done),
    .overflow(d1_ovf)
  );

  pc_trace_buffer #(.HIST_DEPTH(1)) dut2 (
    .clk(clk), .reset(reset), .cpu_stall(cpu_stall), .pc(pc), .inst(inst),
    .rec_ready(rec_ready), .rec_valid(d2_valid), .rec_pc(d2_pc),
    .rec_inst(d2_inst), .rec_seq(d2_seq), .level(d2_level), .done(d2_done),
    .overflow(d2_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the instance under test onto common 32-bit observation signals
  always_comb begin
    cur_valid = d0_valid;
    cur_pc    = d0_pc;
    cur_inst  = d0_inst;
    cur_seq   = {19'b0, d0_seq};
    cur_level = {28'b0, d0_level};
    cur_done  = d0_done;
    cur_ovf   = d0_ovf;
    case (sel)
      1: begin
        cur_valid = d1_valid;
        cur_pc    = d1_pc;
        cur_inst  = d1_inst;
        cur_seq   = {30'b0, d1_seq};
        cur_level = {28'b0, d1_level};
        cur_done  = d1_done;
        cur_ovf   = d1_ovf;
      end
      2: begin
        cur_valid = d2_valid;
        cur_pc    = d2_pc;
        cur_inst  = d2_inst;
        cur_seq   = {19'b0, d2_seq};
        cur_level = {28'b0, d2_level};
        cur_done  = d2_done;
        cur_ovf   = d2_ovf;
      end
      default: ;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // One reset edge; afterwards everything must read idle
  task automatic applyReset(input int which, input int hist, input int max_rec);
    sel       = which;
    reset     = 1'b1;
    cpu_stall = 1'b0;
    pc        = 32'h44;
    inst      = 32'h144;
    rec_ready = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    hq.delete();
    m_last  = '0;
    m_count = 0;
    m_done  = 1'b0;
    m_ovf   = 1'b0;
    m_hist  = hist;
    m_max   = max_rec;
    checkOutput("reset_level", cur_level, 32'd0);
    checkOutput("reset_valid", {31'b0, cur_valid}, 32'd0);
    checkOutput("reset_rec_pc", cur_pc, 32'd0);
    checkOutput("reset_rec_seq", cur_seq, 32'd0);
    checkOutput("reset_done", {31'b0, cur_done}, 32'd0);
    checkOutput("reset_overflow", {31'b0, cur_ovf}, 32'd0);
  endtask

  // Drive one cycle of stimulus, compare the head against the scoreboard,
  // predict what the edge does, then check occupancy and flags after it.
  task automatic applyStimulus(input bit s, input logic [31:0] p,
                               input logic [31:0] i, input bit r);
    bit   pop_m;
    bit   push_m;
    bit   full_m;
    ent_t cand;
    rec_t new_rec;
    cpu_stall = s;
    pc        = p;
    inst      = i;
    rec_ready = r;
    #2;
    pop_m  = (exp_q.size() > 0) && r;
    full_m = (exp_q.size() == 8);
    push_m = 1'b0;
    if (exp_q.size() > 0) begin
      checkOutput("head_valid", {31'b0, cur_valid}, 32'd1);
      checkOutput("head_pc", cur_pc, exp_q[0].pc);
      checkOutput("head_inst", cur_inst, exp_q[0].inst);
      checkOutput("head_seq", cur_seq, 32'(exp_q[0].seq));
    end else begin
      checkOutput("idle_valid", {31'b0, cur_valid}, 32'd0);
      checkOutput("idle_rec_pc", cur_pc, 32'd0);
    end
    if (!s && (p != m_last)) begin
      m_last = p;
      hq.push_front('{pc: p, inst: i});
      if (hq.size() > m_hist) void'(hq.pop_back());
      if (hq.size() == m_hist) begin
        cand = hq[$];
        if (!m_done && (cand.pc != 32'd0)) begin
          if (!full_m || pop_m) begin
            push_m  = 1'b1;
            new_rec = '{pc: cand.pc, inst: cand.inst, seq: m_count};
            m_count++;
            if (m_count == m_max) m_done = 1'b1;
          end else begin
            m_ovf = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (pop_m) void'(exp_q.pop_front());
    if (push_m) exp_q.push_back(new_rec);
    checkOutput("level", cur_level, 32'(exp_q.size()));
    checkOutput("overflow", {31'b0, cur_ovf}, {31'b0, m_ovf});
    checkOutput("done", {31'b0, cur_done}, {31'b0, m_done});
  endtask

  initial begin
    vec_t vecs[14];
    checks    = 0;
    failures  = 0;
    sel       = 0;
    reset     = 1'b1;
    cpu_stall = 1'b0;
    pc        = '0;
    inst      = '0;
    rec_ready = 1'b0;

    // Basic capture, delay, stall and hold behaviour on the default instance
    vecs[0]  = '{stall: 0, pc: 32'h00, ready: 1, exp_level: 0};
    vecs[1]  = '{stall: 0, pc: 32'h04, ready: 1, exp_level: 0};
    vecs[2]  = '{stall: 0, pc: 32'h08, ready: 1, exp_level: 0};
    vecs[3]  = '{stall: 0, pc: 32'h0C, ready: 1, exp_level: 0};
    vecs[4]  = '{stall: 0, pc: 32'h10, ready: 1, exp_level: 0};
    vecs[5]  = '{stall: 0, pc: 32'h14, ready: 0, exp_level: 1};
    vecs[6]  = '{stall: 0, pc: 32'h14, ready: 0, exp_level: 1};
    vecs[7]  = '{stall: 1, pc: 32'h18, ready: 0, exp_level: 1};
    vecs[8]  = '{stall: 1, pc: 32'h1C, ready: 0, exp_level: 1};
    vecs[9]  = '{stall: 0, pc: 32'h14, ready: 0, exp_level: 1};
    vecs[10] = '{stall: 0, pc: 32'h18, ready: 0, exp_level: 2};
    vecs[11] = '{stall: 0, pc: 32'h18, ready: 1, exp_level: 1};
    vecs[12] = '{stall: 0, pc: 32'h18, ready: 1, exp_level: 0};
    vecs[13] = '{stall: 0, pc: 32'h18, ready: 1, exp_level: 0};

    @(posedge clk);
    #1;
    applyReset(0, 5, 5000);
    for (int k = 0; k < 14; k++) begin
      applyStimulus(vecs[k].stall, vecs[k].pc, vecs[k].pc + 32'h100, vecs[k].ready);
      checkOutput($sformatf("vec%0d_level", k), cur_level, 32'(vecs[k].exp_level));
    end
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 32'h18, 32'h118, 1'b0);
    end
    checkOutput("hold_level", cur_level, 32'd0);

    // Fill past capacity with the consumer stalled, then drain in order
    applyReset(0, 5, 5000);
    for (int k = 0; k < 13; k++) begin
      applyStimulus(1'b0, 32'h1000 + 32'(4 * k), 32'h5000 + 32'(k), 1'b0);
    end
    checkOutput("ovf_level_full", cur_level, 32'd8);
    checkOutput("ovf_flag", {31'b0, cur_ovf}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 32'h1030, 32'h500C, 1'b1);
    end
    checkOutput("ovf_drained", cur_level, 32'd0);
    checkOutput("ovf_sticky", {31'b0, cur_ovf}, 32'd1);

    // Full FIFO with a pop and push on the same edge keeps level and flag
    applyReset(0, 5, 5000);
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b0, 32'h1000 + 32'(4 * k), 32'h6000 + 32'(k), 1'b0);
    end
    checkOutput("full_level", cur_level, 32'd8);
    applyStimulus(1'b0, 32'h1030, 32'h600C, 1'b1);
    checkOutput("simul_level", cur_level, 32'd8);
    checkOutput("simul_ovf", {31'b0, cur_ovf}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 32'h1030, 32'h600C, 1'b1);
    end

    // Record limit of three on the second instance
    applyReset(1, 1, 3);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 32'h2000 + 32'(4 * k), 32'h7000 + 32'(k), 1'b0);
      if (k == 1) checkOutput("done_before_third", {31'b0, cur_done}, 32'd0);
      if (k == 2) checkOutput("done_at_third", {31'b0, cur_done}, 32'd1);
    end
    checkOutput("limit_level", cur_level, 32'd3);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 32'h2024, 32'h7009, 1'b1);
    end

    // Zero PC skipped without consuming a sequence number, then mid-run reset
    applyReset(2, 1, 5000);
    applyStimulus(1'b0, 32'h04, 32'h104, 1'b0);
    applyStimulus(1'b0, 32'h00, 32'h100, 1'b0);
    applyStimulus(1'b0, 32'h08, 32'h108, 1'b0);
    checkOutput("skip_level", cur_level, 32'd2);
    checkOutput("skip_head_pc", cur_pc, 32'h04);
    applyStimulus(1'b0, 32'h08, 32'h108, 1'b1);
    checkOutput("skip_second_pc", cur_pc, 32'h08);
    checkOutput("skip_second_seq", cur_seq, 32'd1);
    applyStimulus(1'b0, 32'h08, 32'h108, 1'b1);
    applyStimulus(1'b0, 32'h0C, 32'h10C, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h110, 1'b0);
    applyStimulus(1'b0, 32'h14, 32'h114, 1'b0);
    checkOutput("pre_reset_level", cur_level, 32'd3);
    applyReset(2, 1, 5000);
    applyStimulus(1'b0, 32'h00, 32'h100, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_trace_buffer.md
PC_TRACE_BUFFER -- requirements
Module: pc_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of pc and inst.
REQ-002 SHALL have parameter HIST_DEPTH, default 5 (legal >=1): number of history slots.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8 (power of two, >=2): number of output record entries.
REQ-004 SHALL have parameter MAX_RECORDS, default 5000: record limit; SEQ_W = clog2(MAX_RECORDS+1).
REQ-005 SHALL have parameter SKIP_ZERO, default 1: when 1, records whose pc is 0 are discarded.
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 cpu_stall  input  1  when high, no capture occurs.
REQ-009 pc  input  DATA_W  current fetch PC.
REQ-010 inst  input  DATA_W  instruction at pc.
REQ-011 rec_ready  input  1  consumer accepts the head record.
REQ-012 rec_valid  output  1  head record present.
REQ-013 rec_pc, rec_inst  output  DATA_W each  head record fields.
REQ-014 rec_seq  output  SEQ_W  head record sequence number.
REQ-015 level  output  clog2(FIFO_DEPTH+1)  FIFO occupancy.
REQ-016 done  output  1  sticky: MAX_RECORDS pushed.
REQ-017 overflow  output  1  sticky: a record was dropped because the FIFO was full.

Function
REQ-018 Capture SHALL occur on an edge where cpu_stall=0 and pc != last_pc; on capture, last_pc <= pc.
REQ-019 On capture, the history SHALL shift: hist[i] <= hist[i-1], and hist[0] <= {valid=1, pc, inst}.
REQ-020 The emit candidate on capture SHALL be the entry landing in hist[HIST_DEPTH-1], i.e. the capture HIST_DEPTH-1 captures earlier (for HIST_DEPTH=1, the current capture).
REQ-021 A candidate SHALL be pushed only if it is valid, done=0, and not (SKIP_ZERO=1 and pc=0).
REQ-022 A push SHALL write {pc, inst, seq=count}, then count increments by 1.
REQ-023 done SHALL assert on the edge where count reaches MAX_RECORDS; subsequent candidates are discarded, while captures and history continue.
REQ-024 The FIFO SHALL be first-word-fall-through: a pushed record is visible at rec_* with rec_valid=1 on the cycle after the push edge.
REQ-025 A pop SHALL occur on an edge where rec_valid=1 and rec_ready=1; rec_* SHALL hold stable while rec_valid=1 and rec_ready=0.
REQ-026 When full with a simultaneous pop, the push SHALL be accepted; level is unchanged.
REQ-027 When full without a pop, the push SHALL be dropped: overflow <= 1, count not incremented, and seq not consumed.
REQ-028 Empty with rec_ready=1 SHALL have no effect; rec_valid=0 and rec_* hold 0.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level = pushes - pops, with 0..FIFO_DEPTH exact.
REQ-030 overflow and done SHALL clear only by reset.

Reset
REQ-031 While reset=1 at an edge, the block SHALL set last_pc=0, all hist valid=0, FIFO empty, level=0, count=0, done=0, overflow=0, rec_valid=0, rec_pc=0, rec_inst=0, rec_seq=0.
REQ-032 Reset mid-operation SHALL discard FIFO and history contents; no capture or pop occurs on the reset edge.
REQ-033 pc=0 after reset SHALL not be captured, because last_pc=0.

Verification
REQ-034 Defaults; after reset, captures pc=4,8,C,10,14 (inst=pc+0x100), rec_ready=1 -> no record after the first 4 captures; one cycle after the 5th capture: rec_valid=1, rec_pc=4, rec_inst=0x104, rec_seq=0.
REQ-035 pc held at 8 for 10 cycles, or cpu_stall=1 while pc changes -> no capture, and level unchanged.
REQ-036 rec_ready=0, 9 eligible pushes -> level=8, overflow=1, and pops return seq 0..7 in order.
REQ-037 Full FIFO with rec_ready=1 and a simultaneous push -> level stays 8, overflow stays 0, and the new record's seq=8.
REQ-038 MAX_RECORDS=3, 10 eligible candidates -> exactly 3 records (seq 0,1,2), with done=1 on the 3rd push edge.
REQ-039 SKIP_ZERO=1, HIST_DEPTH=1, captures pc=4,0,8 -> records pc=4 seq 0 and pc=8 seq 1; reset with level=3 -> next cycle rec_valid=0, level=0.
